// File: rtl/cpack_line_packer.sv
// cpack_line_packer: packs LANES variable-length codes per beat into LINE_W-bit lines
module cpack_line_packer #(
  parameter int LANES  = 2,
  parameter int CODE_W = 34,
  parameter int LINE_W = 128,
  parameter int LEN_W  = $clog2(CODE_W + 1)
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [LANES*CODE_W-1:0]   i_code,
  input  logic [LANES*LEN_W-1:0]    i_len,
  input  logic                      i_last,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [LINE_W-1:0]         o_line,
  output logic [$clog2(LINE_W+1)-1:0] o_line_bits,
  output logic                      o_last,
  output logic                      o_len_err,
  output logic [31:0]               o_total_bits
);
  localparam int ACC_W = LINE_W + LANES * CODE_W;
  localparam int FW    = $clog2(ACC_W + 1);
  localparam int BW    = $clog2(LINE_W + 1);
  typedef enum logic {RUN, FLUSH} state_t;
  state_t             state;
  logic [ACC_W-1:0]   acc, ins;
  logic [FW-1:0]      fill, off;
  logic [LEN_W-1:0]   len;
  logic               err, accept, free, full, closing;
  assign full    = fill >= FW'(LINE_W);
  assign o_ready = !full && state == RUN;
  assign accept  = i_valid && o_ready;
  assign free    = !o_valid || i_ready;
  assign closing = state == FLUSH && fill <= FW'(LINE_W);
  // Bits above fill are always zero, so new lanes can be OR-ed in place
  always_comb begin
    ins = '0;
    off = fill;
    err = 1'b0;
    len = '0;
    for (int k = 0; k < LANES; k++) begin
      len = i_len[k*LEN_W +: LEN_W] > LEN_W'(CODE_W) ? LEN_W'(CODE_W) : i_len[k*LEN_W +: LEN_W];
      err = err | (i_len[k*LEN_W +: LEN_W] > LEN_W'(CODE_W));
      ins = ins | (ACC_W'(i_code[k*CODE_W +: CODE_W] & ~({CODE_W{1'b1}} << len)) << off);
      off = off + FW'(len);
    end
  end
  always_ff @(posedge i_clk or negedge i_reset)
    if (!i_reset) begin
      state        <= RUN;
      acc          <= '0;
      fill         <= '0;
      o_valid      <= 1'b0;
      o_line       <= '0;
      o_line_bits  <= '0;
      o_last       <= 1'b0;
      o_len_err    <= 1'b0;
      o_total_bits <= '0;
    end else begin
      if (o_valid && i_ready) o_valid <= 1'b0;
      if (accept) begin
        acc          <= acc | ins;
        fill         <= off;
        o_total_bits <= o_total_bits + 32'(off - fill);
        o_len_err    <= o_len_err | err;
        if (i_last) state <= FLUSH;
      end else if (free && (full || state == FLUSH)) begin
        o_valid     <= 1'b1;
        o_line      <= acc[LINE_W-1:0];
        o_line_bits <= full ? BW'(LINE_W) : BW'(fill);
        o_last      <= closing;
        acc         <= full ? acc >> LINE_W : '0;
        fill        <= full ? fill - FW'(LINE_W) : '0;
        if (closing) state <= RUN;
      end
    end
endmodule
